// File: rtl/conv1_maxpool.sv
// conv1_maxpool: streaming 2x2 stride-2 max-pool that sits directly after conv1.
// Ports: clk, rst (async, active-low), pool_en, in_valid, in_data[CH] -> out_valid,
//        out_data[CH], out_col, out_row, pool_done. Optional macro: POOL_RELU_EN.
module conv1_maxpool #(
   parameter int CH    = 64,
   parameter int WIDTH = 16,
   parameter int W_IN  = 128,
   parameter int H_IN  = 128
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pool_en,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data [0:CH-1],
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data [0:CH-1],
   output logic [$clog2(W_IN/2)-1:0] out_col,
   output logic [$clog2(H_IN/2)-1:0] out_row,
   output logic                      pool_done
);

   localparam int WOUT_P = W_IN / 2;
   localparam int XW     = $clog2(W_IN);
   localparam int YW     = $clog2(H_IN);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_d;

   logic [XW-1:0]    col;
   logic [YW-1:0]    row;
   logic             accept;
   logic             col_last;
   logic             row_last;
   logic [WIDTH-1:0] hold    [0:CH-1];
   logic [WIDTH-1:0] linebuf [0:WOUT_P-1][0:CH-1];
   logic [WIDTH-1:0] h       [0:CH-1];
   logic [WIDTH-1:0] pooled  [0:CH-1];

   function automatic logic [WIDTH-1:0] smax(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      return ($signed(a) >= $signed(b)) ? a : b;
   endfunction

   assign col_last  = (col == XW'(W_IN - 1));
   assign row_last  = (row == YW'(H_IN - 1));
   assign pool_done = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: if (pool_en) state_d = RUN;
         RUN: begin
            accept = pool_en && in_valid;
            if (!pool_en)
               state_d = IDLE;
            else if (accept && col_last && row_last)
               state_d = DONE;
         end
         DONE: if (!pool_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // h: horizontal max of the pair; pooled: h against the stored upper row.
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         h[c]      = smax(hold[c], in_data[c]);
         pooled[c] = smax(linebuf[col[XW-1:1]][c], h[c]);
`ifdef POOL_RELU_EN
         if (pooled[c][WIDTH-1]) pooled[c] = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         col       <= '0;
         row       <= '0;
         out_valid <= 1'b0;
         out_col   <= '0;
         out_row   <= '0;
         for (int c = 0; c < CH; c++) out_data[c] <= '0;
      end else begin
         state_q   <= state_d;
         out_valid <= 1'b0;
         if (!pool_en) begin
            col <= '0;
            row <= '0;
         end else if (accept) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            if (col[0] && row[0]) begin
               out_valid <= 1'b1;
               out_col   <= col[XW-1:1];
               out_row   <= row[YW-1:1];
               for (int c = 0; c < CH; c++) out_data[c] <= pooled[c];
            end
         end
      end
   end

   // Storage without reset: each entry is always written before it is read.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (!col[0]) begin
            for (int c = 0; c < CH; c++) hold[c] <= in_data[c];
         end else if (!row[0]) begin
            for (int c = 0; c < CH; c++) linebuf[col[XW-1:1]][c] <= h[c];
         end
      end
   end

endmodule

// File: tb/tb_conv1_maxpool.sv
// tb_conv1_maxpool: checks conv1_maxpool on a 4x4x2 instance and a default instance
// against a whole-frame max-pool model.
module tb_conv1_maxpool;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        s_en, s_iv, s_ov, s_done;
   logic [15:0] s_in  [0:1];
   logic [15:0] s_out [0:1];
   logic [0:0]  s_oc, s_or;

   logic        b_en, b_iv, b_ov, b_done;
   logic [15:0] b_in  [0:63];
   logic [15:0] b_out [0:63];
   logic [5:0]  b_oc, b_or;

   conv1_maxpool #(.CH(2), .WIDTH(16), .W_IN(4), .H_IN(4)) u_small (
      .clk(clk), .rst(rst), .pool_en(s_en), .in_valid(s_iv), .in_data(s_in),
      .out_valid(s_ov), .out_data(s_out), .out_col(s_oc), .out_row(s_or),
      .pool_done(s_done));

   conv1_maxpool u_big (
      .clk(clk), .rst(rst), .pool_en(b_en), .in_valid(b_iv), .in_data(b_in),
      .out_valid(b_ov), .out_data(b_out), .out_col(b_oc), .out_row(b_or),
      .pool_done(b_done));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mx(input logic [15:0] a, input logic [15:0] b);
      return ($signed(a) >= $signed(b)) ? a : b;
   endfunction

   function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef POOL_RELU_EN
      return x[15] ? 16'h0000 : x;
`else
      return x;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int p; logic [15:0] d0; logic [15:0] d1; int r; int c; logic done;
   } cap_t;
   cap_t cap[$];

   typedef struct {
      int p; logic [15:0] e0; logic [15:0] e1; int r; int c;
   } vec_t;
   vec_t tbl [4];

   logic [15:0] sf [0:3][0:3][0:1];
   logic [15:0] bf [0:127][0:127][0:63];

   task automatic sample_small(input int p);
      cap_t e;
      if (s_ov === 1'b1) begin
         e.p = p; e.d0 = s_out[0]; e.d1 = s_out[1];
         e.r = int'(s_or); e.c = int'(s_oc); e.done = s_done;
         cap.push_back(e);
      end
   endtask

   // gap = cycles between in_valid pulses; 0 picks a random gap of 1..3
   task automatic stream_small(input int gap);
      int g;
      cap.delete();
      s_en = 1'b1; s_iv = 1'b0;
      tick();
      for (int p = 0; p < 16; p++) begin
         s_iv = 1'b1;
         s_in[0] = sf[p/4][p%4][0];
         s_in[1] = sf[p/4][p%4][1];
         tick();
         s_iv = 1'b0;
         sample_small(p);
         g = (gap == 0) ? $urandom_range(1, 3) : gap;
         for (int k = 1; k < g; k++) begin
            tick();
            sample_small(p);
         end
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         sample_small(16);
      end
      s_en = 1'b0;
      tick();
   endtask

   task automatic check_small_model(input string tag);
      logic [15:0] e0, e1;
      int r, c;
      chk({tag, "_count"}, cap.size(), 4);
      for (int k = 0; k < 4 && k < cap.size(); k++) begin
         r = k / 2; c = k % 2;
         e0 = relu(mx(mx(sf[2*r][2*c][0], sf[2*r][2*c+1][0]),
                      mx(sf[2*r+1][2*c][0], sf[2*r+1][2*c+1][0])));
         e1 = relu(mx(mx(sf[2*r][2*c][1], sf[2*r][2*c+1][1]),
                      mx(sf[2*r+1][2*c][1], sf[2*r+1][2*c+1][1])));
         chk($sformatf("%s_p%0d", tag, k), cap[k].p, (2*r+1)*4 + 2*c + 1);
         chk($sformatf("%s_d0_%0d", tag, k), cap[k].d0, e0);
         chk($sformatf("%s_d1_%0d", tag, k), cap[k].d1, e1);
         chk($sformatf("%s_pos%0d", tag, k), {cap[k].r, cap[k].c}, {r, c});
         chk($sformatf("%s_done%0d", tag, k), cap[k].done, (k == 3));
      end
   endtask

   task automatic check_table(input string tag);
      for (int i = 0; i < 4; i++) begin
         if (i < cap.size()) begin
            chk($sformatf("%s_tp%0d", tag, i), cap[i].p, tbl[i].p);
            chk($sformatf("%s_t0_%0d", tag, i), cap[i].d0, tbl[i].e0);
            chk($sformatf("%s_t1_%0d", tag, i), cap[i].d1, tbl[i].e1);
            chk($sformatf("%s_trc%0d", tag, i), {cap[i].r, cap[i].c}, {tbl[i].r, tbl[i].c});
         end else begin
            n_chk++; n_fail++;
            $display("FAIL %s_missing%0d: got none expected pulse", tag, i);
         end
      end
   endtask

   function automatic void t2_frame();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            sf[r][c][0] = 16'(16*r + c);
            sf[r][c][1] = ~sf[r][c][0];
         end
   endfunction

   int nout;

   task automatic sample_big(input int p);
      int r, c, k;
      logic ok;
      logic [15:0] e;
      if (b_ov === 1'b1) begin
         k = nout; r = k / 64; c = k % 64;
         ok = 1'b1;
         for (int ch = 0; ch < 64; ch++) begin
            e = relu(mx(mx(bf[2*r][2*c][ch], bf[2*r][2*c+1][ch]),
                        mx(bf[2*r+1][2*c][ch], bf[2*r+1][2*c+1][ch])));
            if (b_out[ch] !== e) ok = 1'b0;
         end
         chk($sformatf("t3_data%0d", k), ok, 1'b1);
         chk($sformatf("t3_pos%0d", k), {b_or, b_oc, p}, {6'(r), 6'(c), (2*r+1)*128 + 2*c + 1});
         chk($sformatf("t3_done%0d", k), b_done, (k == 4095));
         nout++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; s_en = 1'b0; s_iv = 1'b0; b_en = 1'b0; b_iv = 1'b0;
      for (int i = 0; i < 2; i++) s_in[i] = '0;
      for (int i = 0; i < 64; i++) b_in[i] = '0;

      tbl[0] = '{5,  16'd17, relu(~16'd0),  0, 0};
      tbl[1] = '{7,  16'd19, relu(~16'd2),  0, 1};
      tbl[2] = '{13, 16'd49, relu(~16'd32), 1, 0};
      tbl[3] = '{15, 16'd51, relu(~16'd34), 1, 1};

      tick(); tick();
      chk("rst_s_ov", s_ov, 1'b0);
      chk("rst_s_out", {s_out[0], s_out[1]}, 32'h0);
      chk("rst_s_pos", {s_or, s_oc}, 2'b00);
      chk("rst_s_done", s_done, 1'b0);
      chk("rst_b_state", {b_ov, b_done, b_or, b_oc, b_out[0]}, 0);
      rst = 1'b1;
      tick();

      // T2 back-to-back, T6 conv1 cadence
      t2_frame();
      stream_small(1);
      check_table("t2");
      check_small_model("t2m");
      stream_small(29);
      check_table("t6");

      // T4 signed windows
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            sf[r][c][0] = 16'($urandom);
      sf[0][0][0] = 16'hFFFB; sf[0][1][0] = 16'hFFFD;
      sf[1][0][0] = 16'hFFF8; sf[1][1][0] = 16'hFFFF;
      sf[0][2][0] = 16'hFFFE; sf[0][3][0] = 16'd7;
      sf[1][2][0] = 16'd0;    sf[1][3][0] = 16'd3;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            sf[r][c][1] = sf[r][c][0];
      stream_small(1);
      if (cap.size() >= 2) begin
`ifdef POOL_RELU_EN
         chk("t4_neg", cap[0].d0, 16'h0000);
`else
         chk("t4_neg", cap[0].d0, 16'hFFFF);
`endif
         chk("t4_mix", cap[1].d0, 16'd7);
      end else begin
         n_chk++; n_fail++;
         $display("FAIL t4_count: got %0d expected 4", cap.size());
      end
      check_small_model("t4m");

      // random signed data, random cadence
      for (int n = 0; n < 3; n++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               for (int ch = 0; ch < 2; ch++)
                  sf[r][c][ch] = 16'($urandom);
         stream_small(0);
         check_small_model($sformatf("rnd%0d", n));
      end

      // T1 async reset mid-RUN
      t2_frame();
      s_en = 1'b1; tick();
      for (int p = 0; p < 6; p++) begin
         s_iv = 1'b1; s_in[0] = sf[p/4][p%4][0]; s_in[1] = sf[p/4][p%4][1];
         tick();
      end
      chk("t1_pre", s_out[0], 16'd17);
      s_in[0] = sf[1][2][0]; s_in[1] = sf[1][2][1];
      #2 rst = 1'b0;
      #1;
      chk("t1_ov", s_ov, 1'b0);
      chk("t1_out", {s_out[0], s_out[1]}, 32'h0);
      chk("t1_pos", {s_or, s_oc, s_done}, 3'b000);
      tick();
      chk("t1_hold_ov", s_ov, 1'b0);
      tick();
      chk("t1_hold_out", s_out[0], 16'h0);
      s_iv = 1'b0; rst = 1'b1; s_en = 1'b0;
      tick();
      stream_small(1);
      check_table("t1r");

      // T5 abort after 6 pixels, IDLE pulses ignored, then T3 full frame
      b_en = 1'b1; tick();
      for (int p = 0; p < 6; p++) begin
         b_iv = 1'b1;
         for (int ch = 0; ch < 64; ch++) b_in[ch] = 16'h7FFF;
         tick();
      end
      b_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("t5_idle%0d", k), b_ov, 1'b0);
      end
      b_iv = 1'b0;
      for (int r = 0; r < 128; r++)
         for (int c = 0; c < 128; c++)
            for (int ch = 0; ch < 64; ch++)
               bf[r][c][ch] = 16'($urandom_range(0, 32766));
      nout = 0;
      b_en = 1'b1; tick();
      for (int p = 0; p < 16384; p++) begin
         b_iv = 1'b1;
         for (int ch = 0; ch < 64; ch++) b_in[ch] = bf[p/128][p%128][ch];
         tick();
         sample_big(p);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("t5_done_ov%0d", k), b_ov, 1'b0);
      end
      chk("t5_done_hi", b_done, 1'b1);
      b_iv = 1'b0;
      chk("t3_count", nout, 4096);
      b_en = 1'b0;
      tick();
      chk("t5_done_lo", b_done, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
